// File: rtl/uart_rx_word.sv
// Oversampling UART receiver that packs NBYTES consecutive 8N1 frames (LSB byte first) into one output word.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module uart_rx_word #(
    parameter int NBYTES     = 2,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic                  RxD,
    output logic [8*NBYTES-1:0]   rx_data,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rxd_meta;
    logic                rxd_sync;
    logic                rxd_prev;
    logic                fall_edge;
    logic [CW-1:0]       tick_cnt;
    logic [2:0]          bit_cnt;
    logic                tick_mid;
    logic                tick_full;
    logic                shift_en;
    logic                stop_done;
    logic                stop_take;
    logic [7:0]          shift_reg;
    logic [8*NBYTES-1:0] word_buf;
    logic [8*NBYTES-1:0] word_next;
    logic [IW-1:0]       byte_idx;
`ifdef UART_RX_PARITY_EN
    logic                par_done;
    logic                par_bad;
`endif

    // The serial line idles high, so the synchronizer and edge history reset to 1
    // to avoid a false start edge coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop capture the pre-edge value of the previous stage.
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall_edge = rxd_prev & ~rxd_sync;
    assign tick_mid  = rx_en && (tick_cnt == TICK_HALF);
    assign tick_full = rx_en && (tick_cnt == TICK_LAST);
    assign rx_busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_next = state;
        shift_en   = 1'b0;
        stop_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_done   = 1'b0;
`endif
        case (state)
            S_IDLE:  if (fall_edge) state_next = S_START;
            S_START: if (tick_mid)  state_next = rxd_sync ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick_full) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_full) begin
                    par_done   = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_full) begin
                    stop_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Both counters restart on every state change, so the cycle that sees the start
    // edge never contributes a tick to the START half-bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_next != state) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (rx_en && state != S_IDLE)
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign stop_take = stop_done && !par_bad;
`else
    assign stop_take = stop_done;
`endif

    always_comb begin
        word_next = word_buf;
        word_next[{byte_idx, 3'b000} +: 8] = shift_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the word buffer is a handful of flops, not a RAM, so it is reset along with the rest.
            shift_reg <= '0;
            word_buf  <= '0;
            byte_idx  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (shift_en)
                shift_reg <= {rxd_sync, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
            // A bad parity bit kills the word now; the following stop bit is then ignored.
            if (par_done) begin
                par_bad <= (rxd_sync != ^shift_reg);
                if (rxd_sync != ^shift_reg) begin
                    frame_err <= 1'b1;
                    byte_idx  <= '0;
                end
            end
`endif
            if (stop_take) begin
                if (!rxd_sync) begin
                    frame_err <= 1'b1;
                    byte_idx  <= '0;
                end else if (byte_idx == IDX_LAST) begin
                    rx_data  <= word_next;
                    rx_valid <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    word_buf <= word_next;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: serial frames are bit-banged on RxD while a
// monitor pops expected words from a scoreboard queue on each rx_valid pulse.
`timescale 1ns/1ps

module tb_uart_rx_word;

    localparam int NB       = 2;
    localparam int OS       = 16;
    localparam int TICK_DIV = 54;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_en;
    logic          RxD;
    logic [15:0]   rx_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          frame_err;

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            valid_cnt = 0;
    int            ferr_cnt  = 0;
    logic [15:0]   exp_q[$];

    uart_rx_word #(.NBYTES(NB), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .RxD       (RxD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        rx_en = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            rx_en = 1'b1;
            @(negedge clk);
            rx_en = 1'b0;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; rx_en only changes on the
    // falling edge, so here it still shows the tick the DUT just consumed.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            check("valid_after_tick", 32'(rx_en), 32'd1);
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_err === 1'b1)
            ferr_cnt++;
        if (rx_valid === 1'b1 || frame_err === 1'b1)
            check("valid_ferr_exclusive", 32'(rx_valid & frame_err), 32'd0);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_bit);
        RxD = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_bit);
        send_bit(1'b1);
    endtask
`endif

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2 * BIT_CLKS) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          v0;
        int          f0;
        int          busy_cnt;
        logic [7:0]  abort_byte;
        logic [15:0] btb_words [10];

        rst = 1'b1;
        RxD = 1'b1;
        wait_clks(5);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_busy", 32'(rx_busy), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_clks(BIT_CLKS);

        // Normal word: 0xBC then 0x0A
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(16'h0ABC);
        send_frame(8'hBC, 1'b1);
        send_frame(8'h0A, 1'b1);
        send_bit(1'b1);
        drain("normal_drain");
        check("normal_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("normal_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("normal_rx_data", 32'(rx_data), 32'h0ABC);

        // Glitch: low for 4 ticks, then back high
        v0 = valid_cnt; f0 = ferr_cnt;
        busy_cnt = 0;
        RxD = 1'b0;
        for (int i = 0; i < 12 * TICK_DIV; i++) begin
            if (i == 4 * TICK_DIV) RxD = 1'b1;
            @(negedge clk);
            if (rx_busy === 1'b1) busy_cnt++;
        end
        check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
        check("glitch_busy_bound", 32'(busy_cnt <= 9 * TICK_DIV), 32'd1);
        check("glitch_back_idle", 32'(rx_busy), 32'd0);
        check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_hold", 32'(rx_data), 32'h0ABC);

        // Framing error on 0x55, then a good 0x34/0x12 pair
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        send_bit(1'b1);
        check("ferr_pulse_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_hold", 32'(rx_data), 32'h0ABC);
        exp_q.push_back(16'h1234);
        send_frame(8'h34, 1'b1);
        send_frame(8'h12, 1'b1);
        send_bit(1'b1);
        drain("ferr_drain");
        check("ferr_recover_data", 32'(rx_data), 32'h1234);
        check("ferr_total_cnt", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of data bit 3 of the first byte
        abort_byte = 8'hA5;
        RxD = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) send_bit(abort_byte[i]);
        RxD = abort_byte[3];
        wait_clks(BIT_CLKS / 2);
        check("abort_busy_before_rst", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rx_data", 32'(rx_data), 32'h0);
        check("abort_rx_busy", 32'(rx_busy), 32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_frame_err", 32'(frame_err), 32'd0);
        wait_clks(5);
        RxD = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("abort_stays_idle", 32'(rx_busy), 32'd0);
        v0 = valid_cnt;
        exp_q.push_back(16'hBEEF);
        send_frame(8'hEF, 1'b1);
        send_frame(8'hBE, 1'b1);
        send_bit(1'b1);
        drain("abort_drain");
        check("abort_recover_data", 32'(rx_data), 32'hBEEF);
        check("abort_valid_cnt", 32'(valid_cnt - v0), 32'd1);

        // Ten words back to back, no idle between frames
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int w = 0; w < 10; w++) begin
            btb_words[w] = 16'($urandom);
            exp_q.push_back(btb_words[w]);
        end
        for (int w = 0; w < 10; w++) begin
            send_frame(btb_words[w][7:0], 1'b1);
            send_frame(btb_words[w][15:8], 1'b1);
        end
        send_bit(1'b1);
        drain("btb_drain");
        check("btb_valid_cnt", 32'(valid_cnt - v0), 32'd10);
        check("btb_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("btb_last_data", 32'(rx_data), 32'(btb_words[9]));

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit must be 1
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame_par(8'h07, 1'b0);
        send_bit(1'b1);
        check("par_bad_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
        exp_q.push_back(16'h0007);
        send_frame_par(8'h07, 1'b1);
        send_frame(8'h00, 1'b1);
        send_bit(1'b1);
        drain("par_drain");
        check("par_good_data", 32'(rx_data), 32'h0007);
        check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
        check("par_total_ferr", 32'(ferr_cnt - f0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter NBYTES, default 2: number of serial bytes assembled into one output word.
REQ-002 Parameter OVERSAMPLE, default 16: rx_en ticks per bit period; must be even and at least 4.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_en  input  1  one-clk oversampling tick at OVERSAMPLE x baud rate, from the baud generator.
REQ-006 RxD  input  1  asynchronous serial input; idles high.
REQ-007 rx_data  output  8*NBYTES  last completed word.
REQ-008 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-009 rx_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-010 frame_err  output  1  one-clk pulse on an invalid stop bit or, if enabled, an invalid parity bit.

Function
REQ-011 RxD passes through a 2-FF synchronizer with both flops set to 1; all other logic uses only the synchronized value.
REQ-012 FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-013 Tick counter: log2(OVERSAMPLE) bits; advances only on rx_en; cleared on every state entry.
REQ-014 IDLE -> START on a 1-to-0 transition of synchronized RxD; rx_en is not required for this transition.
REQ-015 START: on tick OVERSAMPLE/2, sample the line.
  - If low: go to DATA.
  - If high (glitch): go to IDLE with no output activity.
REQ-016 DATA: sample every OVERSAMPLE ticks (mid-bit), 8 bits, LSB first, shifted into a byte register; after bit 7 go to PARITY or STOP.
REQ-017 STOP: sample after OVERSAMPLE ticks, then go to IDLE immediately, so the FSM can resync on the next start edge.
  - Stop = 1: byte k (k = 0..NBYTES-1, k = 0 first received) is written to word bits [8k+7:8k], and the byte index increments.
  - Stop = 0: frame_err pulses, the partial word is discarded, the byte index returns to 0, and rx_data is unchanged.
REQ-018 When byte NBYTES-1 completes:
  - rx_data updates and rx_valid pulses one clk after the rx_en tick that sampled the stop bit;
  - the byte index returns to 0.
REQ-019 rx_data holds its value until the next complete word.
REQ-020 There is no receive buffering; the consumer must capture rx_data on the rx_valid cycle.
REQ-021 rx_en asserted during the same cycle as the start edge does not count toward the START tick count.
REQ-022 rx_valid and frame_err are never high in the same cycle.

Reset
REQ-023 On rst: FSM = IDLE; counters and byte index = 0; synchronizer flops = 1; rx_data = 0; rx_valid = 0; frame_err = 0; rx_busy = 0.
REQ-024 rst asserted mid-frame aborts the frame and discards the partial word; after release, reception resumes only on a new start edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN.
  - Defined: after DATA, the PARITY state samples one even-parity bit after OVERSAMPLE ticks. A mismatch pulses frame_err and discards the word exactly as a bad stop bit does; the FSM then continues to STOP and the stop bit is not stored.
  - Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Verification
REQ-026 Clocking for all scenarios: 100 MHz clk, rx_en every 54 clks, OVERSAMPLE=16, NBYTES=2.
REQ-027 Normal word: frames 0xBC then 0x0A -> exactly one rx_valid pulse with rx_data = 16'h0ABC, and frame_err stays 0.
REQ-028 Glitch rejection: RxD low for 4 ticks then high -> returns to IDLE; no rx_valid, no frame_err; rx_busy high for at most 9 ticks.
REQ-029 Framing error: frame 0x55 with stop = 0, then good frames 0x34, 0x12 ->
  - one frame_err pulse;
  - rx_data = 16'h1234 after the good pair;
  - rx_data never reflects 0x55.
REQ-030 Reset mid-frame: rst asserted during DATA bit 3 of the first byte -> all outputs return to reset values; next frames 0xEF, 0xBE -> rx_data = 16'hBEEF.
REQ-031 Back-to-back: 10 words with zero idle between frames -> 10 rx_valid pulses and matching data.
REQ-032 With UART_RX_PARITY_EN: byte 0x07 with parity bit 0 (correct value is 1) -> frame_err pulse, no rx_valid; the same byte with parity 1 is accepted.
